// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI memory slave: FSM states, command
// frame field offsets and the SCLK edge-polarity decode.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // Command frame fields, counted down from the frame MSB: R/W sits at the
  // MSB, the address field starts one bit below it.
  localparam int RW_OFS   = 0;
  localparam int ADDR_OFS = 1;

  typedef struct packed {
    logic lead_rise;    // leading edge is a rising SCLK edge
    logic sample_rise;  // sample edge is a rising SCLK edge
    logic shift_rise;   // shift edge is a rising SCLK edge
  } edge_pol_t;

  // Leading edge leaves the idle level; CPHA picks which edge samples.
  function automatic edge_pol_t edge_pol(input int cpol, input int cpha);
    edge_pol_t p;
    p.lead_rise   = (cpol == 0);
    p.sample_rise = (cpha == 0) ? p.lead_rise : !p.lead_rise;
    p.shift_rise  = !p.sample_rise;
    return p;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser chain for one asynchronous pin followed by a one-flop edge
// detector. Flops reset to the pin's idle level so reset never fakes an edge.
module spi_edge_sync #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the pin through the chain and keep one cycle of history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{IDLE_VAL}};
      prev  <= IDLE_VAL;
    end else begin
      chain[0] <= din;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave with an internal word-addressed memory. Frame 0 carries R/W and
// the start address; later frames are data words with address auto-increment.
// All SPI pins are synchronised into clk and handled on detected edge pulses.
module spi_mem_slave
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int DEPTH       = 2**ADDR_W,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy
);

  localparam edge_pol_t         POL       = edge_pol(CPOL, CPHA);
  localparam int                CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sample_pulse, shift_pulse, frame_done, wr_en, rd_load, miso_q;
  state_t state, state_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next, tx_shift;
  logic [ADDR_W-1:0] addr, addr_inc;
  logic [DATA_W-1:0] mem [DEPTH];

  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'(CPOL))) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall));
  spi_edge_sync #(.STAGES(SYNC_STAGES), .IDLE_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .din(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

  // Only the synchronised mosi level and the sclk/cs edges drive logic.
  logic unused_sync;
  assign unused_sync = ^{sclk_lvl, cs_lvl, mosi_rise, mosi_fall};

  assign sample_pulse = POL.sample_rise ? sclk_rise : sclk_fall;
  assign shift_pulse  = POL.shift_rise  ? sclk_rise : sclk_fall;
  assign rx_next      = {rx_shift, mosi_lvl};
  assign frame_done   = sample_pulse && (bit_cnt == LAST_BIT) && (state != ST_IDLE);
  assign wr_en        = frame_done && (state == ST_WDATA);
  assign addr_inc     = (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state; cs_n rising wins from any state after the current sample is used.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (cs_fall) state_next = ST_CMD;
      ST_CMD:  if (frame_done)
                 state_next = rx_next[DATA_W-1-RW_OFS] ? ST_RDATA : ST_WDATA;
      default: state_next = state;
    endcase
    if (cs_rise) state_next = ST_IDLE;
  end

  // Pad outputs: the pad is driven for the whole transaction, data only when reading.
  always_comb begin
    busy    = (state != ST_IDLE);
    miso_oe = (state != ST_IDLE);
    miso    = (state == ST_RDATA) ? miso_q : 1'b0;
  end

  // Bit counter, receive shifter, address pointer and read-load request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      addr     <= '0;
      rd_load  <= 1'b0;
    end else begin
      rd_load <= 1'b0;
      if (state == ST_IDLE) begin
        if (cs_fall) bit_cnt <= '0;
      end else if (sample_pulse) begin
        rx_shift <= rx_next[DATA_W-2:0];
        if (frame_done) begin
          bit_cnt <= '0;
          if (state == ST_CMD) begin
            addr    <= rx_next[DATA_W-1-ADDR_OFS -: ADDR_W];
            rd_load <= rx_next[DATA_W-1-RW_OFS] && !cs_rise;
          end else if (state == ST_RDATA) begin
            rd_load <= !cs_rise;
          end else begin
            addr <= addr_inc;
          end
        end else begin
          bit_cnt <= bit_cnt + CNT_W'(1);
        end
      end
      if (rd_load) addr <= addr_inc;
    end
  end

  // Memory write port: a completed data frame lands on the clk after its last sample.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= rx_next;
  end

  // TX shifter with the memory read port folded into the load. With CPHA=0
  // the MSB goes out on load and the trailing edge right after a frame's last
  // sample (bit_cnt back at 0) is skipped so it does not eat the next MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
      miso_q   <= 1'b0;
    end else if (state == ST_IDLE || state == ST_CMD) begin
      miso_q <= 1'b0;
    end else if (rd_load) begin
      if (CPHA == 0) begin
        miso_q   <= mem[addr][DATA_W-1];
        tx_shift <= {mem[addr][DATA_W-2:0], 1'b0};
      end else begin
        tx_shift <= mem[addr];
      end
    end else if (shift_pulse && state == ST_RDATA && ((CPHA != 0) || (bit_cnt != '0))) begin
      miso_q   <= tx_shift[DATA_W-1];
      tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_mem_slave.sv
// Bench for spi_mem_slave: three instances (mode 0 8-bit, mode 3 8-bit,
// mode 1 16-bit/10-bit address) driven by a simple SPI master task set.
// A bench-side memory model predicts every read word; a per-cycle process
// checks busy/miso_oe and the mode-3 shift edge.
module tb_spi_mem_slave;

  localparam int H = 8;  // clk cycles per SCLK half period

  logic clk = 1'b0;
  logic rst_n;
  logic [2:0] sclk, cs_n, mosi;
  logic [2:0] miso, miso_oe, busy;

  int n_checks;
  int n_errors;
  logic [2:0] exp_busy, chk_en;
  logic [15:0] model_mem [3][1024];
  logic [15:0] wdat [4];
  logic [15:0] rdat [4];
  logic [15:0] rx;
  logic miso1_prev;

  always #5 clk = ~clk;

  spi_mem_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(0), .CPHA(0)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]),
    .miso(miso[0]), .miso_oe(miso_oe[0]), .busy(busy[0]));
  spi_mem_slave #(.DATA_W(8), .ADDR_W(7), .CPOL(1), .CPHA(1)) u_mode3 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]),
    .miso(miso[1]), .miso_oe(miso_oe[1]), .busy(busy[1]));
  spi_mem_slave #(.DATA_W(16), .ADDR_W(10), .CPOL(0), .CPHA(1)) u_wide (
    .clk(clk), .rst_n(rst_n), .sclk(sclk[2]), .cs_n(cs_n[2]), .mosi(mosi[2]),
    .miso(miso[2]), .miso_oe(miso_oe[2]), .busy(busy[2]));

  // Per-unit configuration.
  function automatic int dw(input int u);  return (u == 2) ? 16 : 8; endfunction
  function automatic int aw(input int u);  return (u == 2) ? 10 : 7; endfunction
  function automatic logic cpol(input int u); return (u == 1); endfunction
  function automatic logic cpha(input int u); return (u != 0); endfunction

  function automatic logic [15:0] mk_cmd(input int u, input logic rw, input int addr);
    return 16'((int'(rw) << (dw(u) - 1)) | (addr << (dw(u) - 1 - aw(u))));
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SPI frame of nbits bits, MSB first; returns the bits seen on miso.
  task automatic spi_frame(input int u, input logic [15:0] tx, input int nbits,
                           output logic [15:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha(u)) begin
        mosi[u] = tx[dw(u) - 1 - i];
        wait_clk(H);
        sclk[u] = ~cpol(u);
        got = {got[14:0], miso[u]};
        wait_clk(H);
        sclk[u] = cpol(u);
      end else begin
        sclk[u] = ~cpol(u);
        mosi[u] = tx[dw(u) - 1 - i];
        wait_clk(H);
        sclk[u] = cpol(u);
        got = {got[14:0], miso[u]};
        wait_clk(H);
      end
    end
  endtask

  task automatic spi_begin(input int u);
    chk_en[u] = 1'b0;
    cs_n[u]   = 1'b0;
    wait_clk(H);
    exp_busy[u] = 1'b1;
    chk_en[u]   = 1'b1;
  endtask

  task automatic spi_end(input int u);
    wait_clk(H);
    chk_en[u]   = 1'b0;
    cs_n[u]     = 1'b1;
    exp_busy[u] = 1'b0;
    wait_clk(4);
    check("miso_oe_drop", miso_oe[u], 16'h0);
    check("busy_drop", busy[u], 16'h0);
    wait_clk(6);
    chk_en[u] = 1'b1;
  endtask

  // Full transaction: writes take wdat[], reads land in rdat[] and are
  // compared against the model memory.
  task automatic xact(input int u, input logic rw, input int addr, input int n);
    logic [15:0] got;
    int a;
    spi_begin(u);
    spi_frame(u, mk_cmd(u, rw, addr), dw(u), got);
    check("cmd_miso_zero", got, 16'h0);
    a = addr;
    for (int i = 0; i < n; i++) begin
      spi_frame(u, rw ? 16'h0 : wdat[i], dw(u), got);
      if (rw) begin
        check("read_word", got, model_mem[u][a]);
        rdat[i] = got;
      end else begin
        model_mem[u][a] = wdat[i];
      end
      a = (a + 1) % (1 << aw(u));
    end
    spi_end(u);
  endtask

  // Per-cycle compare: busy/miso_oe against the expected transaction window,
  // and in mode 3 miso may only move while SCLK is low (after a falling edge).
  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 3; u++) begin
        if (chk_en[u]) begin
          check("busy", busy[u], exp_busy[u]);
          check("miso_oe", miso_oe[u], exp_busy[u]);
        end
      end
      if (miso[1] !== miso1_prev) check("mode3_shift_edge", sclk[1], 16'h0);
    end
    miso1_prev = miso[1];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    cs_n = 3'b111;
    mosi = 3'b000;
    sclk = 3'b010;
    exp_busy = 3'b000;
    chk_en = 3'b000;
    miso1_prev = 1'b0;
    for (int u = 0; u < 3; u++)
      for (int a = 0; a < 1024; a++) model_mem[u][a] = '0;

    // Reset values.
    wait_clk(5);
    for (int u = 0; u < 3; u++) begin
      check("rst_miso", miso[u], 16'h0);
      check("rst_miso_oe", miso_oe[u], 16'h0);
      check("rst_busy", busy[u], 16'h0);
    end
    rst_n = 1'b1;
    wait_clk(5);
    chk_en = 3'b111;

    // Mode 0: single write then read back.
    wdat[0] = 16'h00A5;
    xact(0, 1'b0, 5, 1);
    xact(0, 1'b1, 5, 1);
    check("lit_a5", rdat[0], 16'h00A5);

    // Burst write across the top of memory, burst read back, then addr 0 alone.
    wdat[0] = 16'h0011; wdat[1] = 16'h0022; wdat[2] = 16'h0033;
    xact(0, 1'b0, 7'h7E, 3);
    check("lit_model_wrap", model_mem[0][0], 16'h0033);
    xact(0, 1'b1, 7'h7E, 3);
    check("lit_burst0", rdat[0], 16'h0011);
    check("lit_burst1", rdat[1], 16'h0022);
    check("lit_burst2", rdat[2], 16'h0033);
    xact(0, 1'b1, 0, 1);
    check("lit_wrap_mem0", rdat[0], 16'h0033);

    // Aborted data frame must not write.
    wdat[0] = 16'h00FF;
    xact(0, 1'b0, 2, 1);
    spi_begin(0);
    spi_frame(0, mk_cmd(0, 1'b0, 2), 8, rx);
    check("cmd_miso_zero", rx, 16'h0);
    spi_frame(0, 16'h0000, 5, rx);
    spi_end(0);
    xact(0, 1'b1, 2, 1);
    check("lit_abort_keep", rdat[0], 16'h00FF);

    // Reset in the middle of a read, then a clean transaction.
    spi_begin(0);
    spi_frame(0, mk_cmd(0, 1'b1, 5), 8, rx);
    check("cmd_miso_zero", rx, 16'h0);
    spi_frame(0, 16'h0000, 3, rx);
    chk_en[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_busy[0] = 1'b0;
    check("midrst_miso", miso[0], 16'h0);
    check("midrst_miso_oe", miso_oe[0], 16'h0);
    check("midrst_busy", busy[0], 16'h0);
    cs_n[0] = 1'b1;
    wait_clk(5);
    rst_n = 1'b1;
    wait_clk(10);
    chk_en[0] = 1'b1;
    xact(0, 1'b1, 5, 1);
    check("lit_after_rst", rdat[0], 16'h00A5);

    // Mode 3 round trip.
    wdat[0] = 16'h003C;
    xact(1, 1'b0, 7'h10, 1);
    xact(1, 1'b1, 7'h10, 1);
    check("lit_mode3", rdat[0], 16'h003C);

    // 16-bit mode 1: top address then wrap to 0 in a 2-word read burst.
    wdat[0] = 16'h1234;
    xact(2, 1'b0, 0, 1);
    wdat[0] = 16'hBEEF;
    xact(2, 1'b0, 10'h3FF, 1);
    check("lit_wide_cmd", mk_cmd(2, 1'b1, 10'h3FF), 16'hFFE0);
    xact(2, 1'b1, 10'h3FF, 2);
    check("lit_wide0", rdat[0], 16'hBEEF);
    check("lit_wide1", rdat[1], 16'h1234);

    wait_clk(4);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_mem_slave.md
# spi_mem_slave

Parametrised SPI slave with an internal word-addressed memory. It is the successor to the 8-bit single-mode SPI memory slave: configurable word and address widths, all four SPI modes, and burst transfers with address auto-increment. It sits at the chip boundary. The SPI pins enter through on-block synchronisers, and all logic runs in the `clk` domain.

## Interface

Parameters:
- `DATA_W`, default 8: word width, which is also the SPI frame length.
- `ADDR_W`, default 7: address width. Must satisfy `ADDR_W <= DATA_W-1`.
- `DEPTH`, default `2**ADDR_W`: number of memory words.
- `CPOL`, default 0: SCLK idle level.
- `CPHA`, default 0: sample edge select. 0 samples on the leading edge, 1 samples on the trailing edge.
- `SYNC_STAGES`, default 2: synchroniser flops per input pin.

Ports:
- `clk` input 1: system clock. It is the block's one clock; reset is asynchronous and active-low.
- `rst_n` input 1: asynchronous, active-low reset.
- `sclk` input 1: SPI serial clock, asynchronous to `clk`.
- `cs_n` input 1: chip select, active-low, asynchronous.
- `mosi` input 1: master-out serial data, MSB first.
- `miso` output 1: slave-out serial data, MSB first.
- `miso_oe` output 1: tri-state enable for the `miso` pad.
- `busy` output 1: high while a transaction is open (from `cs_n` low to `cs_n` high, as seen after synchronisation).

## Operation

- Each pin (`sclk`, `cs_n`, `mosi`) passes through `SYNC_STAGES` flops, then a one-flop edge detector.
- Edge definitions:
  - Leading edge = rising when `CPOL=0`, falling when `CPOL=1`.
  - Sample edge = leading edge if `CPHA=0`, trailing edge if `CPHA=1`.
  - Shift edge = the other edge.
- Frame 0 is the command frame: bit `DATA_W-1` is R/W (1 = read), bits `[DATA_W-2 -: ADDR_W]` are the address, and any remaining LSBs are ignored.
- Every later frame is a data frame. After each completed data frame the address increments. Past `DEPTH-1` it wraps to 0.
- FSM states and transitions:
  - IDLE: on `cs_n` falling go to CMD, clear the bit counter, set `busy=1`, `miso_oe=1`.
  - CMD: shift in `DATA_W` sampled bits. On the last bit, latch R/W and address. If R/W=1 go to RDATA; otherwise go to WDATA.
  - WDATA: on the `DATA_W`-th sampled bit, write `mem[addr]` on the next `clk`, then increment `addr`. Stay in WDATA.
  - RDATA: on entry, and at each frame completion, perform a one-cycle synchronous read of `mem[addr]` into the TX shift register, then increment `addr`. The TX register shifts out MSB first.
- Synchronised `cs_n` rising, from any state: go to IDLE, set `busy=0`, `miso_oe=0`. A partial data frame is discarded and no write occurs. A partial command frame is discarded.
- `miso` is 0 throughout the command frame.
- With `CPHA=0`, the MSB of a read word drives `miso` as soon as it is loaded, before the first sample edge of that frame. Each following bit is driven on the shift edge.
- With `CPHA=1`, each bit, MSB included, is driven on the leading edge of its bit period.
- Memory contents are not reset.
- Edge case: `cs_n` rising and the last sample edge detected in the same `clk` cycle. The sample is processed first (write or address commit), then the block returns to IDLE.

## Timing

- Reset values: `miso=0`, `miso_oe=0`, `busy=0`, FSM=IDLE, `addr=0`, bit counter=0, synchroniser flops at the idle level (`sclk=CPOL`, `cs_n=1`).
- Pin-to-edge-pulse latency: `SYNC_STAGES+1` clk cycles.
- Write commit: 1 clk after the detected final sample edge of a data frame.
- Read load: TX register valid 2 clk after the detected final sample edge of the command frame or previous data frame.
- Requirements on the SPI master:
  - `sclk` high and low phases ≥ `SYNC_STAGES+3` clk periods each.
  - `cs_n` setup to the first SCLK edge ≥ `SYNC_STAGES+2` clk periods.
  - `cs_n` high time between transactions ≥ `SYNC_STAGES+2` clk periods.
- Reset asserted mid-transaction: the block immediately returns to IDLE and any in-flight write is lost. After reset is released, the block ignores the bus until the next `cs_n` falling edge.

## Structure

- Package `spi_pkg` holds:
  - the FSM state enum (IDLE, CMD, WDATA, RDATA);
  - localparams for the R/W bit position and the address field offset;
  - a function that derives leading/sample/shift edge polarity from `CPOL`/`CPHA`.
- Sub-module `spi_edge_sync`: synchroniser chain plus rise/fall pulse outputs. It is instantiated once per pin.
- The memory is an inferred array inside the block, with a synchronous read port and a synchronous write port.

## Test plan

- Mode 0, `DATA_W=8`: transaction 1 sends cmd `0x05` (write, addr 5) and data `0xA5`. Transaction 2 sends cmd `0x85` and reads → `miso` yields `0xA5`; `busy` is high only during each transaction.
- Burst write at cmd `0x7E` with `0x11`, `0x22`, `0x33`; then burst read from `0xFE` → returns `0x11`, `0x22`, `0x33`, with `mem[0]=0x33` confirming the wrap.
- Mode 3 (`CPOL=1`, `CPHA=1`): write `0x3C` to addr `0x10` and read it back → `0x3C`. Also check that the MSB changes only on falling SCLK.
- Write `0xFF` to addr 2. In a second transaction, write to addr 2 but raise `cs_n` after 5 data bits → a read of addr 2 returns `0xFF`, and `miso_oe` drops within `SYNC_STAGES+2` clk.
- Assert `rst_n` low mid-read at bit 3 → `miso=0`, `miso_oe=0`, `busy=0` immediately. After release, the next full transaction proceeds normally.
- Parameter sweep `DATA_W=16`, `ADDR_W=10`, mode 1: write `0xBEEF` to addr `0x3FF`, then read addr `0x3FF` in a 2-word burst → `0xBEEF`, then `mem[0]`.
